// File: rtl/gate_vector_sequencer_if.sv
// Purpose : bundles the control/observation signals of gate_vector_sequencer.
// Ports   : start/abort/y_in flow into the sequencer; a_out/b_out/vec_idx/busy/done/pass/fail_mask flow out.
// Modports: master = test controller / gate side, slave = the sequencer itself.
interface gate_vector_sequencer_if;
  logic       start;
  logic       abort;
  logic       y_in;
  logic       a_out;
  logic       b_out;
  logic [1:0] vec_idx;
  logic       busy;
  logic       done;
  logic       pass;
  logic [3:0] fail_mask;

  modport master (
    output start, abort, y_in,
    input  a_out, b_out, vec_idx, busy, done, pass, fail_mask
  );

  modport slave (
    input  start, abort, y_in,
    output a_out, b_out, vec_idx, busy, done, pass, fail_mask
  );
endinterface

// File: rtl/gate_vector_sequencer.sv
// Purpose : drives the four 2-input vectors 00,01,10,11 into a gate, waits SETTLE_CYCLES after each,
//           samples y_in once per vector and compares it with the EXPECT truth table.
// Ports   : clk, rst_n (async active-low); gv (slave modport) carries start/abort/y_in in and
//           a_out/b_out/vec_idx/busy/done/pass/fail_mask out. DONE is entered 4*(SETTLE_CYCLES+1)
//           edges after start is accepted; start is only honoured in IDLE, abort wins over start.
module gate_vector_sequencer #(
  parameter int unsigned SETTLE_CYCLES = 2,        // legal range 1..15
  parameter logic [3:0]  EXPECT        = 4'b0001   // bit i = expected y for vector i = {a,b}
) (
  input  logic                  clk,
  input  logic                  rst_n,
  gate_vector_sequencer_if.slave gv
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SETTLE = 2'd1,
    SAMPLE = 2'd2,
    DONE   = 2'd3
  } state_t;

  // Counter runs 0..SETTLE_CYCLES-1 so SETTLE lasts exactly SETTLE_CYCLES cycles.
  localparam logic [3:0] LAST_CNT = 4'(SETTLE_CYCLES - 1);

  state_t     state_q, state_d;
  logic [3:0] cnt_q,   cnt_d;
  logic [1:0] idx_q,   idx_d;
  logic [3:0] fail_q,  fail_d;
  logic       pass_q,  pass_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= 4'd0;
      idx_q   <= 2'd0;
      fail_q  <= 4'd0;
      pass_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      fail_q  <= fail_d;
      pass_q  <= pass_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    idx_d   = idx_q;
    fail_d  = fail_q;
    pass_d  = pass_q;

    case (state_q)
      IDLE: begin
        // abort held together with start keeps us idle
        if (gv.start && !gv.abort) begin
          state_d = SETTLE;
          cnt_d   = 4'd0;
          idx_d   = 2'd0;
          fail_d  = 4'd0;
          pass_d  = 1'b0;
        end
      end

      SETTLE: begin
        if (gv.abort) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          idx_d   = 2'd0;
          fail_d  = 4'd0;
          pass_d  = 1'b0;
        end else if (cnt_q == LAST_CNT) begin
          state_d = SAMPLE;
        end else begin
          cnt_d = cnt_q + 4'd1;
        end
      end

      SAMPLE: begin
        if (gv.abort) begin
          state_d = IDLE;
          cnt_d   = 4'd0;
          idx_d   = 2'd0;
          fail_d  = 4'd0;
          pass_d  = 1'b0;
        end else begin
          fail_d[idx_q] = (gv.y_in != EXPECT[idx_q]);
          if (idx_q == 2'd3) begin
            // pass is registered here so it is already valid during the DONE cycle
            state_d = DONE;
            pass_d  = (fail_d == 4'd0);
          end else begin
            state_d = SETTLE;
            idx_d   = idx_q + 2'd1;
            cnt_d   = 4'd0;
          end
        end
      end

      DONE: begin
        // vector 11 stays applied through DONE and drops back to 00 with IDLE
        state_d = IDLE;
        idx_d   = 2'd0;
        cnt_d   = 4'd0;
      end

      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // a/b come straight from the index register, so vec_idx == {a_out,b_out} always holds.
  assign gv.a_out     = idx_q[1];
  assign gv.b_out     = idx_q[0];
  assign gv.vec_idx   = idx_q;
  assign gv.busy      = (state_q == SETTLE) || (state_q == SAMPLE);
  assign gv.done      = (state_q == DONE);
  assign gv.pass      = pass_q;
  assign gv.fail_mask = fail_q;

endmodule
